// File: rtl/fp16_defs.sv
// fp16_defs: shared FP16 field widths, special encodings and accumulator FSM states
package fp16_defs;
   localparam int EXP_W = 5;
   localparam int MAN_W = 10;
   localparam int BIAS  = 15;
   localparam logic [15:0] FP16_PINF = 16'h7C00;
   localparam logic [15:0] FP16_NINF = 16'hFC00;
   localparam logic [15:0] FP16_QNAN = 16'h7E00;
   localparam logic [15:0] FP16_ZERO = 16'h0000;
   typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_RESULT, S_OUT} state_e;
endpackage

// File: rtl/fp16_align_shift.sv
// fp16_align_shift: decode two FP16 operands, order by magnitude, align the smaller, flag infinities
module fp16_align_shift
   import fp16_defs::*;
(
   input  logic [15:0]      a_i,
   input  logic [15:0]      b_i,
   output logic [MAN_W:0]   sig_big_o,
   output logic [MAN_W:0]   sig_small_o,
   output logic [EXP_W-1:0] exp_big_o,
   output logic             sign_o,
   output logic             sub_o,
   output logic             special_o,
   output logic [15:0]      special_val_o
);
   logic             a_zero, b_zero, a_inf, b_inf, a_big;
   logic [EXP_W-1:0] ea, eb, diff;
   logic [MAN_W:0]   sa, sb, small_raw;
   assign a_zero = a_i[14:10] == '0;
   assign b_zero = b_i[14:10] == '0;
   assign a_inf  = &a_i[14:10];
   assign b_inf  = &b_i[14:10];
   assign ea = a_zero ? '0 : a_i[14:10];
   assign eb = b_zero ? '0 : b_i[14:10];
   assign sa = a_zero ? '0 : {1'b1, a_i[9:0]};
   assign sb = b_zero ? '0 : {1'b1, b_i[9:0]};
   assign a_big       = {ea, sa} >= {eb, sb};
   assign exp_big_o   = a_big ? ea : eb;
   assign sig_big_o   = a_big ? sa : sb;
   assign small_raw   = a_big ? sb : sa;
   assign diff        = exp_big_o - (a_big ? eb : ea);
   assign sig_small_o = diff >= 5'd12 ? '0 : small_raw >> diff;
   assign sign_o      = a_big ? a_i[15] : b_i[15];
   assign sub_o       = a_i[15] ^ b_i[15];
   assign special_o   = a_inf | b_inf;
   assign special_val_o = (a_inf & b_inf & (a_i[15] ^ b_i[15])) ? FP16_QNAN :
                          (a_inf ? a_i[15] : b_i[15]) ? FP16_NINF : FP16_PINF;
endmodule

// File: rtl/fp16_accum_stage.sv
// fp16_accum_stage: accumulate FP16 product terms into a running sum and emit it on the last term
module fp16_accum_stage
   import fp16_defs::*;
#(
   parameter int CNT_W = 8
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [15:0]      out_data,
   output logic [CNT_W-1:0] out_count
);
   state_e           state_q, state_d;
   logic [15:0]      acc_q, acc_d, op_q, op_d, res_q, res_d, al_special_val;
   logic [CNT_W-1:0] count_q, count_d;
   logic             last_q, last_d, sign_q, sign_d, sub_q, sub_d;
   logic             in_ready_q, out_valid_q, al_sign, al_sub, al_special;
   logic [MAN_W:0]   big_q, big_d, small_q, small_d, al_big, al_small;
   logic [MAN_W+1:0] sum_q, sum_d;
   logic [EXP_W:0]   exp_q, exp_d, exp_inc;
   logic [EXP_W-1:0] al_exp;
   fp16_align_shift u_align (
      .a_i(acc_q), .b_i(op_q), .sig_big_o(al_big), .sig_small_o(al_small), .exp_big_o(al_exp),
      .sign_o(al_sign), .sub_o(al_sub), .special_o(al_special), .special_val_o(al_special_val)
   );
   assign exp_inc   = exp_q + 6'd1;
   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = acc_q;
   assign out_count = count_q;
   // next-state and datapath: latch, align, add, normalise one bit per cycle, commit, present
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      op_d    = op_q;
      res_d   = res_q;
      count_d = count_q;
      last_d  = last_q;
      sign_d  = sign_q;
      sub_d   = sub_q;
      big_d   = big_q;
      small_d = small_q;
      sum_d   = sum_q;
      exp_d   = exp_q;
      case (state_q)
         S_IDLE: if (in_valid && in_ready_q) begin
            op_d    = in_data;
            last_d  = in_last;
            count_d = &count_q ? count_q : count_q + CNT_W'(1);
            state_d = S_ALIGN;
         end
         S_ALIGN: begin
            big_d   = al_big;
            small_d = al_small;
            exp_d   = {1'b0, al_exp};
            sign_d  = al_sign;
            sub_d   = al_sub;
            res_d   = al_special_val;
            state_d = al_special ? S_RESULT : S_ADD;
         end
         S_ADD: begin
            sum_d   = sub_q ? {1'b0, big_q} - {1'b0, small_q} : {1'b0, big_q} + {1'b0, small_q};
            state_d = S_NORM;
         end
         S_NORM: begin
            state_d = S_RESULT;
            if (sum_q[11])
               res_d = exp_inc >= 6'd31 ? (sign_q ? FP16_NINF : FP16_PINF) : {sign_q, exp_inc[4:0], sum_q[10:1]};
            else if (sum_q == '0 || (!sum_q[10] && exp_q <= 6'd1))
               res_d = FP16_ZERO;
            else if (sum_q[10])
               res_d = {sign_q, exp_q[4:0], sum_q[9:0]};
            else begin
               sum_d   = sum_q << 1;
               exp_d   = exp_q - 6'd1;
               state_d = S_NORM;
            end
         end
         S_RESULT: begin
            acc_d   = res_q;
            state_d = last_q ? S_OUT : S_IDLE;
         end
         S_OUT: if (out_ready) begin
            acc_d   = FP16_ZERO;
            count_d = '0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end
   // control state, accumulator, term count and registered handshake flags
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         acc_q       <= FP16_ZERO;
         count_q     <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         count_q     <= count_d;
         in_ready_q  <= state_d == S_IDLE;
         out_valid_q <= state_d == S_OUT;
      end
   end
   // operand and intermediate datapath registers; only meaningful once the FSM has loaded them
   always_ff @(posedge clk) begin
      op_q    <= op_d;
      res_q   <= res_d;
      last_q  <= last_d;
      sign_q  <= sign_d;
      sub_q   <= sub_d;
      big_q   <= big_d;
      small_q <= small_d;
      sum_q   <= sum_d;
      exp_q   <= exp_d;
   end
endmodule
